// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single synchronous-read memory.
// Every transaction takes three cycles: accept, memory strobe, response.
module mem_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp0_valid,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Handshake: a request transfers on a clock edge where reqN_valid and
  // reqN_ready are both high; ready is only ever raised in IDLE, for the
  // single requester chosen by arbitration, and carries no other meaning.

  state_t            state;
  logic              last_grant;
  logic              lat_id;
  logic              lat_we;
  logic [DATA_W-1:0] rdata_q;
  logic              gnt_id;
  logic              accept;

  assign gnt_id     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign accept     = (state == IDLE) && (req0_valid || req1_valid) && !reset;
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept && gnt_id;
  assign dbg_state  = state;

  // Read data arrives from the memory in the RESP cycle itself, so it is
  // forwarded then and captured in rdata_q to be held until the next response.
  always_comb begin
    resp_rdata = rdata_q;
    if (state == RESP) resp_rdata = lat_we ? '0 : mem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      lat_id      <= 1'b0;
      lat_we      <= 1'b0;
      rdata_q     <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
    end else begin
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= gnt_id;
            lat_id     <= gnt_id;
            lat_we     <= gnt_id ? req1_we : req0_we;
            mem_en     <= 1'b1;
            mem_we     <= gnt_id ? req1_we : req0_we;
            mem_addr   <= gnt_id ? req1_addr : req0_addr;
            mem_wdata  <= gnt_id ? req1_wdata : req0_wdata;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          resp0_valid <= !lat_id;
          resp1_valid <= lat_id;
          state       <= RESP;
        end
        RESP: begin
          rdata_q <= lat_we ? '0 : mem_rdata;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed corner sequences and a
// randomized phase checked against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int AW = 19;
  localparam int DW = 19;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_we, req0_ready;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_we, req1_ready;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          resp0_valid, resp1_valid;
  logic [DW-1:0] resp_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // clock / reset
  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_rdata(resp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // synchronous-read memory with a deterministic background pattern
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    if (a == 19'h00005) return 19'h7ABCD;
    return a ^ 19'h15A5A;
  endfunction

  logic [DW-1:0] mem    [0:(1<<AW)-1];
  bit            mem_wr [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr]    <= mem_wdata;
      mem_wr[mem_addr] <= 1'b1;
    end
    if (mem_en && !mem_we)
      mem_rdata <= mem_wr[mem_addr] ? mem[mem_addr] : init_word(mem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic id, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    if (!id) begin
      req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d;
    end
  endtask

  // one isolated transaction from IDLE, checked cycle by cycle
  task automatic run_txn(input logic id, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                         input string tag);
    drive_req(id, we, a, d);
    @(negedge clk);
    chk({tag, ".ready0"}, req0_ready, !id);
    chk({tag, ".ready1"}, req1_ready, id);
    adv();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".mem_en"}, mem_en, 1);
    chk({tag, ".mem_we"}, mem_we, we);
    chk({tag, ".mem_addr"}, mem_addr, a);
    if (we) chk({tag, ".mem_wdata"}, mem_wdata, d);
    adv();
    @(negedge clk);
    chk({tag, ".resp0"}, resp0_valid, !id);
    chk({tag, ".resp1"}, resp1_valid, id);
    chk({tag, ".rdata"}, resp_rdata, exp_rd);
    chk({tag, ".mem_en_off"}, mem_en, 0);
    adv();
  endtask

  typedef struct {
    logic          v0, v1, we0, we1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          e_r0, e_r1, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
  } vec_t;

  vec_t tbl [9];

  // transaction-level reference model state
  typedef struct {
    int            acc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          id;
  } txn_t;

  txn_t          txq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_mem [logic [AW-1:0]];

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(32'h40000, 32'h7FFFE));
    return AW'($urandom_range(32'h40, 32'h4F));
  endfunction

  initial begin
    logic          m_lg;
    logic [DW-1:0] hold;
    logic          rdy0, rdy1;

    // after reset (last_grant=1) requester 0 wins the first contention
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 19'h00100, 19'h00100, 19'h11111, 19'h0,
               1'b1, 1'b0, 1'b1, 19'h00100, 19'h11111, 19'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 19'h00200, 19'h00100, 19'h0, 19'h0,
               1'b0, 1'b1, 1'b0, 19'h00100, 19'h0, 19'h11111};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 19'h7FFFF, 19'h00100, 19'h7FFFF, 19'h0,
               1'b1, 1'b0, 1'b1, 19'h7FFFF, 19'h7FFFF, 19'h0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 19'h0, 19'h00200, 19'h0, 19'h2BEEF,
               1'b0, 1'b1, 1'b1, 19'h00200, 19'h2BEEF, 19'h0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 19'h0, 19'h7FFFF, 19'h0, 19'h0,
               1'b0, 1'b1, 1'b0, 19'h7FFFF, 19'h0, 19'h7FFFF};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 19'h00200, 19'h00100, 19'h0, 19'h0,
               1'b1, 1'b0, 1'b0, 19'h00200, 19'h0, 19'h2BEEF};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 19'h00100, 19'h0, 19'h0, 19'h0,
               1'b1, 1'b0, 1'b0, 19'h00100, 19'h0, 19'h11111};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 19'h00100, 19'h00200, 19'h0, 19'h0,
               1'b0, 1'b1, 1'b0, 19'h00200, 19'h0, 19'h2BEEF};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 19'h0, 19'h0, 19'h0, 19'h0,
               1'b0, 1'b0, 1'b0, 19'h0, 19'h0, 19'h2BEEF};

    // reset state, with both requesters valid to confirm ready stays low
    reset = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    @(negedge clk);
    chk("rst.ready0", req0_ready, 0);
    chk("rst.ready1", req1_ready, 0);
    chk("rst.mem_en", mem_en, 0);
    chk("rst.mem_we", mem_we, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.resp0", resp0_valid, 0);
    chk("rst.resp1", resp1_valid, 0);
    chk("rst.rdata", resp_rdata, 0);
    chk("rst.state", dbg_state, 0);
    adv();
    reset = 1'b0;

    // vector table: each row is one 3-cycle slot starting right after reset
    for (int i = 0; i < 9; i++) begin
      req0_valid = tbl[i].v0; req0_we = tbl[i].we0;
      req0_addr = tbl[i].a0; req0_wdata = tbl[i].d0;
      req1_valid = tbl[i].v1; req1_we = tbl[i].we1;
      req1_addr = tbl[i].a1; req1_wdata = tbl[i].d1;
      @(negedge clk);
      chk($sformatf("tbl%0d.ready0", i), req0_ready, tbl[i].e_r0);
      chk($sformatf("tbl%0d.ready1", i), req1_ready, tbl[i].e_r1);
      adv();
      @(negedge clk);
      chk($sformatf("tbl%0d.busy_ready", i), {req0_ready, req1_ready}, 0);
      chk($sformatf("tbl%0d.mem_en", i), mem_en, tbl[i].e_r0 | tbl[i].e_r1);
      if (tbl[i].e_r0 | tbl[i].e_r1) begin
        chk($sformatf("tbl%0d.mem_we", i), mem_we, tbl[i].e_we);
        chk($sformatf("tbl%0d.mem_addr", i), mem_addr, tbl[i].e_addr);
        if (tbl[i].e_we) chk($sformatf("tbl%0d.mem_wdata", i), mem_wdata, tbl[i].e_wdata);
      end
      adv();
      @(negedge clk);
      chk($sformatf("tbl%0d.busy_ready2", i), {req0_ready, req1_ready}, 0);
      chk($sformatf("tbl%0d.resp0", i), resp0_valid, tbl[i].e_r0);
      chk($sformatf("tbl%0d.resp1", i), resp1_valid, tbl[i].e_r1);
      chk($sformatf("tbl%0d.rdata", i), resp_rdata, tbl[i].e_rdata);
      adv();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // single read, single write, read-back
    run_txn(1'b0, 1'b0, 19'h00005, 19'h0, 19'h7ABCD, "rd5");
    run_txn(1'b1, 1'b1, 19'h00010, 19'h12345, 19'h0, "wr10");
    run_txn(1'b0, 1'b0, 19'h00010, 19'h0, 19'h12345, "rd10");

    // late request: req1 rises while req0 is in ISSUE
    drive_req(1'b0, 1'b0, 19'h00005, 19'h0);
    @(negedge clk);
    chk("late.T.ready0", req0_ready, 1);
    adv();
    req0_valid = 1'b0;
    drive_req(1'b1, 1'b0, 19'h00010, 19'h0);
    @(negedge clk);
    chk("late.T1.ready1", req1_ready, 0);
    chk("late.T1.mem_en", mem_en, 1);
    adv();
    @(negedge clk);
    chk("late.T2.ready1", req1_ready, 0);
    chk("late.T2.resp0", resp0_valid, 1);
    chk("late.T2.rdata", resp_rdata, 19'h7ABCD);
    adv();
    @(negedge clk);
    chk("late.T3.ready1", req1_ready, 1);
    chk("late.T3.ready0", req0_ready, 0);
    adv();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("late.T4.mem_addr", mem_addr, 19'h00010);
    chk("late.T4.mem_en", mem_en, 1);
    adv();
    @(negedge clk);
    chk("late.T5.resp1", resp1_valid, 1);
    chk("late.T5.resp0", resp0_valid, 0);
    chk("late.T5.rdata", resp_rdata, 19'h12345);
    adv();
    @(negedge clk);
    chk("late.T6.no_dup", {req0_ready, req1_ready, mem_en, resp1_valid}, 0);
    adv();

    // reset pulsed while a transaction is in ISSUE
    drive_req(1'b0, 1'b0, 19'h00010, 19'h0);
    @(negedge clk);
    chk("abort.ready0", req0_ready, 1);
    adv();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort.ready", {req0_ready, req1_ready}, 0);
    chk("abort.mem_en", mem_en, 0);
    chk("abort.mem_we", mem_we, 0);
    chk("abort.mem_addr", mem_addr, 0);
    chk("abort.resp", {resp0_valid, resp1_valid}, 0);
    chk("abort.rdata", resp_rdata, 0);
    adv();
    reset = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("abort.after.mem_en", mem_en, 0);
    chk("abort.after.resp", {resp0_valid, resp1_valid}, 0);
    adv();
    run_txn(1'b1, 1'b0, 19'h00010, 19'h0, 19'h12345, "post_abort");

    // randomized traffic against the reference model
    reset = 1'b1;
    adv();
    reset = 1'b0;
    m_lg = 1'b1;
    hold = '0;
    txq.delete();
    exp_q.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      bit   free;
      logic e0, e1;
      @(negedge clk);
      free = (txq.size() == 0);
      if (!free && txq[0].acc + 1 == cyc) begin
        chk("rnd.mem_en", mem_en, 1);
        chk("rnd.mem_we", mem_we, txq[0].we);
        chk("rnd.mem_addr", mem_addr, txq[0].addr);
        if (txq[0].we) chk("rnd.mem_wdata", mem_wdata, txq[0].wdata);
      end else begin
        chk("rnd.mem_en_idle", mem_en, 0);
        chk("rnd.mem_we_idle", mem_we, 0);
      end
      if (!free && txq[0].acc + 2 == cyc) begin
        chk("rnd.resp0", resp0_valid, !txq[0].id);
        chk("rnd.resp1", resp1_valid, txq[0].id);
        hold = exp_q.pop_front();
        void'(txq.pop_front());
      end else begin
        chk("rnd.resp_idle", {resp0_valid, resp1_valid}, 0);
      end
      chk("rnd.rdata", resp_rdata, hold);
      e0 = 1'b0; e1 = 1'b0;
      if (free && (req0_valid || req1_valid)) begin
        txn_t t;
        t.id = (req0_valid && req1_valid) ? !m_lg : req1_valid;
        m_lg = t.id;
        t.acc = cyc;
        t.we = t.id ? req1_we : req0_we;
        t.addr = t.id ? req1_addr : req0_addr;
        t.wdata = t.id ? req1_wdata : req0_wdata;
        txq.push_back(t);
        if (t.we) begin
          exp_q.push_back('0);
          model_mem[t.addr] = t.wdata;
        end else begin
          exp_q.push_back(model_mem.exists(t.addr) ? model_mem[t.addr] : init_word(t.addr));
        end
        e0 = !t.id;
        e1 = t.id;
      end
      chk("rnd.ready0", req0_ready, e0);
      chk("rnd.ready1", req1_ready, e1);
      rdy0 = req0_ready;
      rdy1 = req1_ready;
      adv();
      // requesters: hold payload until ready, occasionally withdraw
      if (rdy0 || !req0_valid) begin
        if ($urandom_range(0, 2) == 0 || rdy0) begin
          req0_valid = rdy0 ? 1'($urandom_range(0, 1)) : 1'b1;
          req0_we = 1'($urandom_range(0, 1));
          req0_addr = rand_addr();
          req0_wdata = DW'($urandom());
        end
      end else if ($urandom_range(0, 15) == 0) begin
        req0_valid = 1'b0;
      end
      if (rdy1 || !req1_valid) begin
        if ($urandom_range(0, 2) == 0 || rdy1) begin
          req1_valid = rdy1 ? 1'($urandom_range(0, 1)) : 1'b1;
          req1_we = 1'($urandom_range(0, 1));
          req1_addr = rand_addr();
          req1_wdata = DW'($urandom());
        end
      end else if ($urandom_range(0, 15) == 0) begin
        req1_valid = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, the address width.
REQ-002 SHALL have parameter DATA_W, default 19, the data width (CPU word).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports req0_valid/req1_valid, input, 1 bit each: request pending, where requester 0 is instruction fetch and requester 1 is data access.
REQ-006 SHALL have ports req0_we/req1_we, input, 1 bit each: 1 = write, 0 = read.
REQ-007 SHALL have ports req0_addr/req1_addr, input, ADDR_W bits each: request address.
REQ-008 SHALL have ports req0_wdata/req1_wdata, input, DATA_W bits each: write data.
REQ-009 SHALL have ports req0_ready/req1_ready, output, 1 bit each: request accepted this cycle.
REQ-010 SHALL have ports resp0_valid/resp1_valid, output, 1 bit each: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, DATA_W bits: read data, shared by both requesters.
REQ-012 SHALL have ports mem_en and mem_we, output, 1 bit each: memory strobe and write enable.
REQ-013 SHALL have port mem_addr, output, ADDR_W bits; and port mem_wdata, output, DATA_W bits.
REQ-014 SHALL have port mem_rdata, input, DATA_W bits: synchronous-read data, valid in the cycle after a cycle with mem_en=1 and mem_we=0.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE and RESP; transitions SHALL be IDLE->ISSUE on accept, ISSUE->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-016 In IDLE, when any reqN_valid=1, SHALL assert the selected reqN_ready combinationally for exactly that cycle.
REQ-016 (cont.) On that same edge, SHALL latch we/addr/wdata and the grant ID, then go to ISSUE.
REQ-017 SHALL accept at most one request per transaction; only one reqN_ready SHALL be high in any cycle.
REQ-018 SHALL hold reqN_ready low outside IDLE, whatever the valid inputs.
REQ-019 Arbitration SHALL be round-robin on a 1-bit last_grant pointer.
REQ-019 (cont.) If both requesters are valid, SHALL grant the requester not equal to last_grant; if only one is valid, SHALL grant it.
REQ-019 (cont.) SHALL update last_grant to the granted ID at accept.
REQ-020 In ISSUE, SHALL drive mem_en=1 and mem_we/mem_addr/mem_wdata from the latched request for exactly one cycle.
REQ-021 SHALL hold mem_en=0 in every other cycle.
REQ-022 SHALL hold mem_we=0 when mem_en=0.
REQ-023 In RESP, SHALL pulse resp_valid of the latched grant ID for one cycle.
REQ-023 (cont.) On a read, resp_rdata SHALL equal mem_rdata; on a write, resp_rdata SHALL be 0.
REQ-024 SHALL register resp_rdata and hold it between responses.
REQ-025 Transaction latency SHALL be fixed: accept in cycle T, mem_en in cycle T+1, resp_valid in cycle T+2, next accept possible in cycle T+3.
REQ-026 A requester SHALL hold valid and payload stable until it sees ready.
REQ-026 (cont.) The arbiter SHALL sample the payload only at accept; valid dropped before accept SHALL cause no transaction.
REQ-027 A valid asserted during ISSUE or RESP SHALL be arbitrated in the next IDLE cycle, with no loss and no starvation.
REQ-027 (cont.) With both requesters continuously valid, grants SHALL strictly alternate 0,1,0,1...
REQ-028 Address and data SHALL pass through unmodified at full ADDR_W/DATA_W width, with no wrap or truncation.

Reset
REQ-029 On reset=1, asynchronously, SHALL set the FSM to IDLE and last_grant=1, so that requester 0 wins the first contention.
REQ-029 (cont.) All registered outputs SHALL go to 0: mem_en, mem_we, mem_addr, mem_wdata, resp0_valid, resp1_valid and resp_rdata.
REQ-030 While reset=1, SHALL hold req0_ready=req1_ready=0.
REQ-031 Reset asserted in ISSUE or RESP SHALL abort the transaction: no resp_valid pulse, and no mem_en in the cycle after reset deasserts.
REQ-032 After deassertion, SHALL accept a request in the first clock edge's cycle.

Verification
REQ-033 Single read: req0 read addr 0x00005, memory holds 0x7ABCD -> req0_ready in cycle T; mem_en=1, mem_we=0, mem_addr=0x00005 in T+1; resp0_valid=1, resp_rdata=0x7ABCD in T+2.
REQ-034 Single write: req1 write addr 0x00010, data 0x12345 -> mem_en=1, mem_we=1, mem_wdata=0x12345 in T+1; resp1_valid=1, resp_rdata=0 in T+2; a following read of 0x00010 returns 0x12345.
REQ-035 Contention after reset: both valid from the first cycle -> req0 granted first, then req1 at T+3, then req0 at T+6; never both readys high.
REQ-036 Late request: req1 rises during req0's ISSUE -> req1_ready in the IDLE cycle T+3; no dropped or duplicated transaction.
REQ-037 Reset mid-operation: reset pulsed in ISSUE -> outputs are 0, no resp pulse; the next request completes normally with 3-cycle latency.
REQ-038 Full-width data: write 0x7FFFF to addr 0x7FFFF, then read it -> resp_rdata=0x7FFFF.
